ofs_fim_axis_pipeline_stage: RTL and testbench



---
 rtl/ofs_fim_axis_pipeline_stage_if.sv | 17 +
 rtl/ofs_fim_axis_pipeline_stage.sv | 146 ++++++++++++++
 tb/tb_ofs_fim_axis_pipeline_stage.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofs_fim_axis_pipeline_stage_if.sv
// AXI-stream bundle used between PCIe SS shim stages: data, byte keep, last and an opaque vendor sideband.
interface pcie_ss_axis_if #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10
);
    // A beat transfers on a rising edge where tvalid && tready are both high; once the
    // source raises tvalid it holds tvalid and the whole payload steady until that edge.
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic [USER_W-1:0]     tuser_vendor;

    modport source (output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
    modport sink   (input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
endinterface

// File: rtl/ofs_fim_axis_pipeline_stage.sv
// Chainable AXI-stream register slice: skid buffer (MODE 0), ready-pass-through register (MODE 1)
// or plain wires (MODE 2 / PL_DEPTH 0). Payload content and order are never altered.
module ofs_fim_axis_pipeline_stage #(
    parameter int MODE        = 0,
    parameter int PL_DEPTH    = 1,
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10
) (
    input  logic           clk,
    input  logic           rst,
    pcie_ss_axis_if.sink   axis_s,
    pcie_ss_axis_if.source axis_m
);
    localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;
    localparam int PW          = TDATA_WIDTH + TKEEP_WIDTH + 1 + TUSER_WIDTH;
    localparam bit BYPASS      = (MODE == 2) || (PL_DEPTH == 0);
    localparam int NS          = BYPASS ? 1 : PL_DEPTH;

    if (BYPASS) begin : g_bypass
        assign axis_m.tvalid       = axis_s.tvalid;
        assign axis_m.tdata        = axis_s.tdata;
        assign axis_m.tkeep        = axis_s.tkeep;
        assign axis_m.tlast        = axis_s.tlast;
        assign axis_m.tuser_vendor = axis_s.tuser_vendor;
        assign axis_s.tready       = axis_m.tready;
    end else begin : g_pipe
        for (genvar k = 0; k < NS; k++) begin : g_stage
            logic          s_valid;
            logic          s_ready;
            logic [PW-1:0] s_pay;
            logic          m_valid;
            logic          m_ready;
            logic [PW-1:0] m_pay;

            if (k == 0) begin : g_in_port
                assign s_valid = axis_s.tvalid;
                assign s_pay   = {axis_s.tdata, axis_s.tkeep, axis_s.tlast, axis_s.tuser_vendor};
                assign axis_s.tready = s_ready;
            end else begin : g_in_chain
                assign s_valid = g_stage[k-1].m_valid;
                assign s_pay   = g_stage[k-1].m_pay;
            end

            if (k == NS - 1) begin : g_out_port
                assign m_ready = axis_m.tready;
            end else begin : g_out_chain
                assign m_ready = g_stage[k+1].s_ready;
            end

            if (MODE == 0) begin : g_skid
                logic          main_valid_q, main_valid_d;
                logic          skid_valid_q, skid_valid_d;
                logic          rdy_q, rdy_d;
                logic [PW-1:0] main_q, main_d;
                logic [PW-1:0] skid_q, skid_d;
                logic          s_acc;
                logic          m_drain;

                always_comb begin
                    main_valid_d = main_valid_q;
                    skid_valid_d = skid_valid_q;
                    main_d       = main_q;
                    skid_d       = skid_q;
                    s_acc        = s_valid && rdy_q;
                    m_drain      = main_valid_q && m_ready;
                    // rdy_q mirrors !skid_valid_q, so the skid refill and a new accept never coincide.
                    if (!main_valid_q || m_drain) begin
                        if (skid_valid_q) begin
                            main_d       = skid_q;
                            main_valid_d = 1'b1;
                            skid_valid_d = 1'b0;
                        end else if (s_acc) begin
                            main_d       = s_pay;
                            main_valid_d = 1'b1;
                        end else begin
                            main_valid_d = 1'b0;
                        end
                    end else if (s_acc) begin
                        skid_d       = s_pay;
                        skid_valid_d = 1'b1;
                    end
                    rdy_d = !skid_valid_d;
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        main_valid_q <= 1'b0;
                        skid_valid_q <= 1'b0;
                        rdy_q        <= 1'b0;
                    end else begin
                        main_valid_q <= main_valid_d;
                        skid_valid_q <= skid_valid_d;
                        rdy_q        <= rdy_d;
                    end
                end

                // Payload holding registers carry no reset; only the valid/ready state does.
                always_ff @(posedge clk) begin
                    main_q <= main_d;
                    skid_q <= skid_d;
                end

                assign s_ready = rdy_q;
                assign m_valid = main_valid_q;
                assign m_pay   = main_q;
            end else begin : g_reg
                logic          valid_q, valid_d;
                logic [PW-1:0] data_q, data_d;
                logic          s_rdy;
                logic          load;

                always_comb begin
                    s_rdy   = !valid_q || m_ready;
                    load    = s_valid && s_rdy;
                    valid_d = valid_q;
                    data_d  = data_q;
                    if (load) begin
                        valid_d = 1'b1;
                        data_d  = s_pay;
                    end else if (m_ready) begin
                        valid_d = 1'b0;
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        valid_q <= 1'b0;
                    end else begin
                        valid_q <= valid_d;
                    end
                end

                always_ff @(posedge clk) begin
                    data_q <= data_d;
                end

                assign s_ready = s_rdy;
                assign m_valid = valid_q;
                assign m_pay   = data_q;
            end
        end

        assign axis_m.tvalid = g_stage[NS-1].m_valid;
        assign {axis_m.tdata, axis_m.tkeep, axis_m.tlast, axis_m.tuser_vendor} = g_stage[NS-1].m_pay;
    end
endmodule

// File: tb/tb_ofs_fim_axis_pipeline_stage.sv
// Bench for ofs_fim_axis_pipeline_stage: four instances (skid depth 1, skid depth 3, register, bypass)
// driven by directed steps, with a per-instance expected queue checked at the output.
module tb_ofs_fim_axis_pipeline_stage;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int UW = 10;
  localparam int PW = DW + KW + 1 + UW;
  localparam int ND = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // index 0: MODE 0 depth 1, 1: MODE 0 depth 3, 2: MODE 1 depth 1, 3: MODE 2 bypass
  logic [ND-1:0] s_valid, s_ready, m_valid, m_ready;
  logic [ND-1:0] m_ready_dir, rnd_rdy, rand_en, mon_en;
  logic [PW-1:0] s_pay [ND];
  logic [PW-1:0] m_pay [ND];

  assign m_ready = (rand_en & rnd_rdy) | (~rand_en & m_ready_dir);

  for (genvar g = 0; g < ND; g++) begin : g_dut
    pcie_ss_axis_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
    pcie_ss_axis_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

    assign s_if.tvalid = s_valid[g];
    assign {s_if.tdata, s_if.tkeep, s_if.tlast, s_if.tuser_vendor} = s_pay[g];
    assign s_ready[g]  = s_if.tready;
    assign m_valid[g]  = m_if.tvalid;
    assign m_pay[g]    = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser_vendor};
    assign m_if.tready = m_ready[g];

    ofs_fim_axis_pipeline_stage #(
      .MODE        ((g == 2) ? 1 : ((g == 3) ? 2 : 0)),
      .PL_DEPTH    ((g == 1) ? 3 : 1),
      .TDATA_WIDTH (DW),
      .TUSER_WIDTH (UW)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .axis_s (s_if),
      .axis_m (m_if)
    );
  end

  initial begin
    rnd_rdy = '0;
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy = ND'($urandom);
    end
  end

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q [ND][$];
  logic          prev_stall [ND];
  logic [PW-1:0] prev_pay [ND];
  int            pass_cnt = 0;
  int            fail_cnt = 0;
  int            total    = 0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (rst) begin
        exp_q[i].delete();
        prev_stall[i] = 1'b0;
      end else if (mon_en[i]) begin
        if (prev_stall[i]) begin
          chk($sformatf("hold_valid_d%0d", i), PW'(m_valid[i]), PW'(1));
          chk($sformatf("hold_payload_d%0d", i), m_pay[i], prev_pay[i]);
        end
        if (s_valid[i] && s_ready[i]) exp_q[i].push_back(s_pay[i]);
        if (m_valid[i] && m_ready[i]) begin
          if (exp_q[i].size() == 0) chk($sformatf("spurious_beat_d%0d", i), PW'(exp_q[i].size()), PW'(1));
          else chk($sformatf("payload_d%0d", i), m_pay[i], exp_q[i].pop_front());
        end
        prev_stall[i] = m_valid[i] && !m_ready[i];
        prev_pay[i]   = m_pay[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [PW-1:0] mk_pay(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                           input logic l, input logic [UW-1:0] u);
    return {d, k, l, u};
  endfunction

  function automatic logic [PW-1:0] rnd_pay();
    return mk_pay({$urandom, $urandom}, KW'($urandom), 1'($urandom), UW'($urandom));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds tvalid with payload p until accepted; returns cycles spent (1 = accepted first try).
  task automatic send(input int i, input logic [PW-1:0] p, output int waits);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    s_pay[i]   = p;
    s_valid[i] = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      #1;
      acc = s_ready[i];
      tick();
      n++;
    end
    waits = n;
    if (!acc) chk($sformatf("send_timeout_d%0d", i), PW'(acc), PW'(1));
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (exp_q[i].size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk($sformatf("drain_d%0d", i), PW'(exp_q[i].size()), PW'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   w;
    int   wsum;
    int   lat;
    int   seq;
    logic acc;

    s_valid     = '0;
    m_ready_dir = '0;
    rand_en     = '0;
    mon_en      = 4'b0111;
    for (int i = 0; i < ND; i++) s_pay[i] = mk_pay(DW'(100 + i), '1, 1'b0, UW'(i));
    s_valid = '1;

    // Reset held for 3 cycles with tvalid high on every input.
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_m_valid", PW'(m_valid[2:0]), PW'(0));
      chk("rst_s_ready_mode0", PW'(s_ready[1:0]), PW'(0));
      chk("rst_s_ready_mode1", PW'(s_ready[2]), PW'(1));
      chk("rst_bypass_valid", PW'(m_valid[3]), PW'(s_valid[3]));
      chk("rst_bypass_payload", m_pay[3], s_pay[3]);
      tick();
    end
    rst     = 1'b0;
    s_valid = '0;
    @(negedge clk);
    #1;
    chk("release_s_ready_early", PW'(s_ready[1:0]), PW'(0));
    tick();
    @(negedge clk);
    #1;
    chk("release_s_ready", PW'(s_ready[1:0]), PW'(2'b11));
    tick();

    // Streaming: 8 back-to-back beats through skid depth 1.
    m_ready_dir[0] = 1'b1;
    chk("stream_empty", PW'(m_valid[0]), PW'(0));
    send(0, mk_pay(DW'(0), '1, 1'b0, UW'(0)), w);
    wsum = w;
    chk("stream_latency_d1", PW'(m_valid[0]), PW'(1));
    for (int b = 1; b < 8; b++) begin
      send(0, mk_pay(DW'(b), '1, (b == 7), UW'(b)), w);
      wsum += w;
    end
    s_valid[0] = 1'b0;
    chk("stream_accept_cycles", PW'(wsum), PW'(8));
    tick();
    chk("stream_out_left", PW'(exp_q[0].size()), PW'(0));
    chk("stream_out_valid", PW'(m_valid[0]), PW'(0));

    // Stall absorption: downstream ready low for cycles 4..7 of a continuous stream.
    seq        = 200;
    s_pay[0]   = mk_pay(DW'(seq), '1, 1'b0, UW'(seq));
    s_valid[0] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      m_ready_dir[0] = !(c >= 4 && c < 8);
      @(negedge clk);
      #1;
      if (c == 4) chk("stall_ready_first", PW'(s_ready[0]), PW'(1));
      if (c == 5) chk("stall_ready_drop", PW'(s_ready[0]), PW'(0));
      if (c == 7) chk("stall_occupancy", PW'(exp_q[0].size()), PW'(2));
      if (c == 8) chk("stall_ready_still_low", PW'(s_ready[0]), PW'(0));
      if (c == 9) chk("stall_ready_rise", PW'(s_ready[0]), PW'(1));
      acc = s_ready[0];
      tick();
      if (acc) begin
        seq++;
        s_pay[0] = mk_pay(DW'(seq), '1, 1'b0, UW'(seq));
      end
    end
    s_valid[0] = 1'b0;
    drain(0);

    // Reset mid-stream: buffered beats are discarded and never emitted.
    m_ready_dir[0] = 1'b0;
    send(0, mk_pay(DW'(300), '1, 1'b0, UW'(1)), w);
    send(0, mk_pay(DW'(301), '1, 1'b1, UW'(2)), w);
    s_valid[0] = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("midrst_m_valid", PW'(m_valid[2:0]), PW'(0));
    rst = 1'b0;
    m_ready_dir[0] = 1'b1;
    repeat (3) tick();
    chk("midrst_no_stale", PW'(m_valid[0]), PW'(0));
    send(0, mk_pay(DW'(302), '1, 1'b1, UW'(3)), w);
    s_valid[0] = 1'b0;
    drain(0);

    // Register mode: ready follows downstream in the same cycle.
    m_ready_dir[2] = 1'b0;
    send(2, mk_pay(DW'(400), '1, 1'b0, UW'(4)), w);
    @(negedge clk);
    #1;
    chk("mode1_full_stall_ready", PW'(s_ready[2]), PW'(0));
    m_ready_dir[2] = 1'b1;
    #1;
    chk("mode1_ready_follows", PW'(s_ready[2]), PW'(1));
    tick();
    wsum = 0;
    for (int b = 0; b < 8; b++) begin
      send(2, mk_pay(DW'(410 + b), KW'(b), (b == 7), UW'(b)), w);
      wsum += w;
    end
    chk("mode1_accept_cycles", PW'(wsum), PW'(8));
    m_ready_dir[2] = 1'b0;
    #1;
    chk("mode1_ready_drop", PW'(s_ready[2]), PW'(0));
    s_valid[2] = 1'b0;
    m_ready_dir[2] = 1'b1;
    drain(2);

    // Depth 3: first-beat latency, then stall capacity.
    m_ready_dir[1] = 1'b1;
    send(1, mk_pay(DW'(500), '1, 1'b1, UW'(5)), w);
    s_valid[1] = 1'b0;
    lat = 1;
    while (!m_valid[1] && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency_d3", PW'(lat), PW'(3));
    m_ready_dir[1] = 1'b0;
    seq        = 600;
    s_pay[1]   = mk_pay(DW'(seq), '1, 1'b0, UW'(seq));
    s_valid[1] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      #1;
      acc = s_ready[1];
      tick();
      if (acc) begin
        seq++;
        s_pay[1] = mk_pay(DW'(seq), '1, 1'b0, UW'(seq));
      end
    end
    @(negedge clk);
    #1;
    chk("capacity_d3", PW'(exp_q[1].size()), PW'(6));
    chk("capacity_ready_d3", PW'(s_ready[1]), PW'(0));
    tick();

    // Depth 3 under random valid/ready with random sideband and keep.
    rand_en[1] = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        s_valid[1] = 1'b0;
        tick();
      end
      send(1, rnd_pay(), w);
    end
    s_valid[1]     = 1'b0;
    rand_en[1]     = 1'b0;
    m_ready_dir[1] = 1'b1;
    drain(1);

    // Bypass: outputs are the inputs in the same cycle.
    for (int n = 0; n < 16; n++) begin
      s_valid[3]     = 1'($urandom);
      s_pay[3]       = rnd_pay();
      m_ready_dir[3] = 1'($urandom);
      #1;
      chk("bypass_valid", PW'(m_valid[3]), PW'(s_valid[3]));
      chk("bypass_payload", m_pay[3], s_pay[3]);
      chk("bypass_ready", PW'(s_ready[3]), PW'(m_ready[3]));
      tick();
    end
    s_valid[3] = 1'b0;

    for (int i = 0; i < 3; i++) chk($sformatf("final_empty_d%0d", i), PW'(exp_q[i].size()), PW'(0));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total);
    $fatal(1, "watchdog");
  end
endmodule
